// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle for pipe_hazard_ctrl.
// slave  : the hazard controller (consumes stage fields, drives controls)
// master : the pipeline datapath (drives stage fields, consumes controls)
// Stage fields: ID sources, ID/EX sources/dest/load flag, EX/MEM and MEM/WB
// destinations, redirect request and counter clear.
// Controls: PC/IFID write enables, three flushes, EX forward selects,
// ID WB-bypass flags, stall flag and four performance counters.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic              id_use_rs1_i;
  logic              id_use_rs2_i;
  logic [REG_AW-1:0] ex_rs1_i;
  logic [REG_AW-1:0] ex_rs2_i;
  logic [REG_AW-1:0] ex_rd_i;
  logic              ex_reg_wr_i;
  logic              ex_mem_rd_i;
  logic [REG_AW-1:0] mem_rd_i;
  logic              mem_reg_wr_i;
  logic [REG_AW-1:0] wb_rd_i;
  logic              wb_reg_wr_i;
  logic              redirect_i;
  logic              cnt_clr_i;

  logic              pc_wr_en_o;
  logic              if_id_wr_en_o;
  logic              if_id_flush_o;
  logic              id_ex_flush_o;
  logic              ex_mem_flush_o;
  logic [1:0]        fwd_a_sel_o;
  logic [1:0]        fwd_b_sel_o;
  logic              id_byp_a_o;
  logic              id_byp_b_o;
  logic              stall_o;
  logic [CNT_W-1:0]  cyc_cnt_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;
  logic [CNT_W-1:0]  retire_cnt_o;

  modport slave (
    input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
    input  ex_rs1_i, ex_rs2_i, ex_rd_i, ex_reg_wr_i, ex_mem_rd_i,
    input  mem_rd_i, mem_reg_wr_i, wb_rd_i, wb_reg_wr_i,
    input  redirect_i, cnt_clr_i,
    output pc_wr_en_o, if_id_wr_en_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
    output fwd_a_sel_o, fwd_b_sel_o, id_byp_a_o, id_byp_b_o, stall_o,
    output cyc_cnt_o, stall_cnt_o, flush_cnt_o, retire_cnt_o
  );

  modport master (
    output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
    output ex_rs1_i, ex_rs2_i, ex_rd_i, ex_reg_wr_i, ex_mem_rd_i,
    output mem_rd_i, mem_reg_wr_i, wb_rd_i, wb_reg_wr_i,
    output redirect_i, cnt_clr_i,
    input  pc_wr_en_o, if_id_wr_en_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
    input  fwd_a_sel_o, fwd_b_sel_o, id_byp_a_o, id_byp_b_o, stall_o,
    input  cyc_cnt_o, stall_cnt_o, flush_cnt_o, retire_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and occupancy controller for a 5-stage RV32 pipeline.
// Ports: clk, rst (synchronous, active high), bus (pipe_hazard_ctrl_if.slave).
// Tracks one valid bit per pipeline register, detects RAW / load-use hazards,
// drives PC/IFID enables, bubble flushes, EX forward selects and ID WB bypass,
// and keeps cycle/stall/flush/retire counters. Redirects resolve in MEM.
module pipe_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 32,
  parameter int FWD_EN    = 1,
  parameter int WB_BYPASS = 1
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  logic r_v_ifid, r_v_idex, r_v_exmem, r_v_memwb;
  logic [CNT_W-1:0] r_cyc_cnt, r_stall_cnt, r_flush_cnt, r_retire_cnt;

  logic w_redir, w_ex_q, w_mem_q, w_wb_q;
  logic w_id_ex_raw, w_id_mem_raw, w_id_wb_raw;
  logic w_lu, w_raw_hz, w_hz, w_stall;
  logic [1:0] w_fwd_a, w_fwd_b;

  assign w_redir = bus.redirect_i & r_v_exmem;

  // A stage is a real writer only when valid and targeting a non-x0 register.
  assign w_ex_q  = r_v_idex  & bus.ex_reg_wr_i  & (bus.ex_rd_i  != '0);
  assign w_mem_q = r_v_exmem & bus.mem_reg_wr_i & (bus.mem_rd_i != '0);
  assign w_wb_q  = r_v_memwb & bus.wb_reg_wr_i  & (bus.wb_rd_i  != '0);

  assign w_id_ex_raw  = (bus.id_use_rs1_i & (bus.id_rs1_i == bus.ex_rd_i))
                      | (bus.id_use_rs2_i & (bus.id_rs2_i == bus.ex_rd_i));
  assign w_id_mem_raw = (bus.id_use_rs1_i & (bus.id_rs1_i == bus.mem_rd_i))
                      | (bus.id_use_rs2_i & (bus.id_rs2_i == bus.mem_rd_i));
  assign w_id_wb_raw  = (bus.id_use_rs1_i & (bus.id_rs1_i == bus.wb_rd_i))
                      | (bus.id_use_rs2_i & (bus.id_rs2_i == bus.wb_rd_i));

  assign w_lu = r_v_ifid & w_ex_q & bus.ex_mem_rd_i & w_id_ex_raw;

  // Without forwarding every in-flight producer blocks ID; WB only matters
  // when the register file cannot pass the same-cycle write through.
  assign w_raw_hz = r_v_ifid & ((w_ex_q & w_id_ex_raw)
                              | (w_mem_q & w_id_mem_raw)
                              | ((WB_BYPASS == 0) & w_wb_q & w_id_wb_raw));

  assign w_hz    = (FWD_EN != 0) ? w_lu : w_raw_hz;
  assign w_stall = w_hz & ~w_redir & ~rst;

  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if ((FWD_EN != 0) && r_v_idex && !rst) begin
      if (w_mem_q && (bus.mem_rd_i == bus.ex_rs1_i))     w_fwd_a = 2'b10;
      else if (w_wb_q && (bus.wb_rd_i == bus.ex_rs1_i))  w_fwd_a = 2'b01;
      if (w_mem_q && (bus.mem_rd_i == bus.ex_rs2_i))     w_fwd_b = 2'b10;
      else if (w_wb_q && (bus.wb_rd_i == bus.ex_rs2_i))  w_fwd_b = 2'b01;
    end
  end

  always_comb begin
    bus.pc_wr_en_o     = 1'b1;
    bus.if_id_wr_en_o  = 1'b1;
    bus.if_id_flush_o  = 1'b0;
    bus.id_ex_flush_o  = 1'b0;
    bus.ex_mem_flush_o = 1'b0;
    bus.stall_o        = 1'b0;
    bus.fwd_a_sel_o    = w_fwd_a;
    bus.fwd_b_sel_o    = w_fwd_b;
    bus.id_byp_a_o     = (WB_BYPASS != 0) & r_v_ifid & bus.id_use_rs1_i & w_wb_q
                       & (bus.wb_rd_i == bus.id_rs1_i);
    bus.id_byp_b_o     = (WB_BYPASS != 0) & r_v_ifid & bus.id_use_rs2_i & w_wb_q
                       & (bus.wb_rd_i == bus.id_rs2_i);
    if (rst) begin
      bus.pc_wr_en_o     = 1'b0;
      bus.if_id_wr_en_o  = 1'b0;
      bus.if_id_flush_o  = 1'b1;
      bus.id_ex_flush_o  = 1'b1;
      bus.ex_mem_flush_o = 1'b1;
      bus.id_byp_a_o     = 1'b0;
      bus.id_byp_b_o     = 1'b0;
    end else if (w_redir) begin
      bus.if_id_flush_o  = 1'b1;
      bus.id_ex_flush_o  = 1'b1;
      bus.ex_mem_flush_o = 1'b1;
    end else if (w_stall) begin
      bus.pc_wr_en_o     = 1'b0;
      bus.if_id_wr_en_o  = 1'b0;
      bus.id_ex_flush_o  = 1'b1;
      bus.stall_o        = 1'b1;
    end
  end

  // The redirecting instruction itself moves on to MEM/WB and retires; only
  // the three younger slots (IF fetch, IF/ID, ID/EX) are squashed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v_ifid  <= 1'b0;
      r_v_idex  <= 1'b0;
      r_v_exmem <= 1'b0;
      r_v_memwb <= 1'b0;
    end else begin
      r_v_memwb <= r_v_exmem;
      r_v_exmem <= r_v_idex & ~w_redir;
      r_v_idex  <= r_v_ifid & ~w_redir & ~w_stall;
      r_v_ifid  <= w_redir ? 1'b0 : (w_stall ? r_v_ifid : 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr_i) begin
      r_cyc_cnt    <= '0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + 1'b1;
      if (w_stall)   r_stall_cnt  <= r_stall_cnt + 1'b1;
      if (w_redir)   r_flush_cnt  <= r_flush_cnt + 1'b1;
      if (r_v_memwb) r_retire_cnt <= r_retire_cnt + 1'b1;
    end
  end

  assign bus.cyc_cnt_o    = r_cyc_cnt;
  assign bus.stall_cnt_o  = r_stall_cnt;
  assign bus.flush_cnt_o  = r_flush_cnt;
  assign bus.retire_cnt_o = r_retire_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with forwarding
// (FWD_EN=1, WB_BYPASS=1) and one stalling instance (FWD_EN=0, WB_BYPASS=1).
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) ifa ();
  pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) ifb ();

  pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(32), .FWD_EN(1), .WB_BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(32), .FWD_EN(0), .WB_BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent traffic: every stage writes a distinct non-zero rd, no overlap.
  task automatic a_idle();
    ifa.id_rs1_i = 5'd10; ifa.id_rs2_i = 5'd11;
    ifa.id_use_rs1_i = 1'b1; ifa.id_use_rs2_i = 1'b1;
    ifa.ex_rs1_i = 5'd12; ifa.ex_rs2_i = 5'd13;
    ifa.ex_rd_i = 5'd1; ifa.ex_reg_wr_i = 1'b1; ifa.ex_mem_rd_i = 1'b0;
    ifa.mem_rd_i = 5'd2; ifa.mem_reg_wr_i = 1'b1;
    ifa.wb_rd_i = 5'd3; ifa.wb_reg_wr_i = 1'b1;
    ifa.redirect_i = 1'b0; ifa.cnt_clr_i = 1'b0;
  endtask

  task automatic b_idle();
    ifb.id_rs1_i = '0; ifb.id_rs2_i = '0;
    ifb.id_use_rs1_i = 1'b0; ifb.id_use_rs2_i = 1'b0;
    ifb.ex_rs1_i = '0; ifb.ex_rs2_i = '0;
    ifb.ex_rd_i = '0; ifb.ex_reg_wr_i = 1'b0; ifb.ex_mem_rd_i = 1'b0;
    ifb.mem_rd_i = '0; ifb.mem_reg_wr_i = 1'b0;
    ifb.wb_rd_i = '0; ifb.wb_reg_wr_i = 1'b0;
    ifb.redirect_i = 1'b0; ifb.cnt_clr_i = 1'b0;
  endtask

  initial begin
    a_idle();
    b_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc_wr", ifa.pc_wr_en_o, 0);
    chk("rst_ifid_wr", ifa.if_id_wr_en_o, 0);
    chk("rst_ifid_fl", ifa.if_id_flush_o, 1);
    chk("rst_idex_fl", ifa.id_ex_flush_o, 1);
    chk("rst_exmem_fl", ifa.ex_mem_flush_o, 1);
    chk("rst_stall", ifa.stall_o, 0);
    chk("rst_fwd_a", ifa.fwd_a_sel_o, 0);
    chk("rst_byp_a", ifa.id_byp_a_o, 0);
    chk("rst_b_pc_wr", ifb.pc_wr_en_o, 0);
    rst = 1'b0;
    #1;
    chk("rel_cyc", ifa.cyc_cnt_o, 0);
    chk("rel_retire", ifa.retire_cnt_o, 0);
    chk("rel_stall", ifa.stall_o, 0);

    // Eight-plus independent ops filling the pipe.
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("alu_pc_wr", ifa.pc_wr_en_o, 1);
      chk("alu_retire", ifa.retire_cnt_o, (i > 4) ? i - 4 : 0);
    end
    chk("alu_cyc12", ifa.cyc_cnt_o, 12);
    chk("alu_stall_cnt", ifa.stall_cnt_o, 0);
    chk("alu_retire8", ifa.retire_cnt_o, 8);
    chk("alu_fwd_a", ifa.fwd_a_sel_o, 0);

    // Forwarding priority (all stages valid).
    ifa.ex_rs1_i = 5'd5; ifa.ex_rs2_i = 5'd5; ifa.mem_rd_i = 5'd5;
    #1;
    chk("fwd_a_mem", ifa.fwd_a_sel_o, 2'b10);
    chk("fwd_b_mem", ifa.fwd_b_sel_o, 2'b10);
    ifa.mem_rd_i = 5'd2; ifa.wb_rd_i = 5'd5;
    #1;
    chk("fwd_a_wb", ifa.fwd_a_sel_o, 2'b01);
    ifa.mem_rd_i = 5'd5;
    #1;
    chk("fwd_a_both", ifa.fwd_a_sel_o, 2'b10);
    ifa.mem_reg_wr_i = 1'b0;
    #1;
    chk("fwd_a_memnowr", ifa.fwd_a_sel_o, 2'b01);
    ifa.mem_reg_wr_i = 1'b1;
    ifa.ex_rs1_i = 5'd0; ifa.ex_rs2_i = 5'd0; ifa.mem_rd_i = 5'd0; ifa.wb_rd_i = 5'd0;
    #1;
    chk("fwd_a_x0", ifa.fwd_a_sel_o, 2'b00);
    chk("fwd_b_x0", ifa.fwd_b_sel_o, 2'b00);
    chk("fwd_stall", ifa.stall_o, 0);

    // Load-use: lw x7 in ID/EX, ID reads rs2 = x7.
    a_idle();
    ifa.ex_rd_i = 5'd7; ifa.ex_mem_rd_i = 1'b1; ifa.id_rs2_i = 5'd7;
    #1;
    chk("lu_stall", ifa.stall_o, 1);
    chk("lu_pc_wr", ifa.pc_wr_en_o, 0);
    chk("lu_ifid_wr", ifa.if_id_wr_en_o, 0);
    chk("lu_idex_fl", ifa.id_ex_flush_o, 1);
    chk("lu_ifid_fl", ifa.if_id_flush_o, 0);
    chk("lu_exmem_fl", ifa.ex_mem_flush_o, 0);
    tick();
    // Bubble in ID/EX (stale load fields must be ignored), load in EX/MEM.
    ifa.mem_rd_i = 5'd7; ifa.mem_reg_wr_i = 1'b1;
    #1;
    chk("lu2_stall", ifa.stall_o, 0);
    chk("lu2_pc_wr", ifa.pc_wr_en_o, 1);
    chk("lu2_stall_cnt", ifa.stall_cnt_o, 1);
    tick();
    // Dependent in EX, load in MEM/WB, EX/MEM holds the bubble.
    ifa.ex_rs2_i = 5'd7; ifa.ex_rd_i = 5'd8; ifa.ex_mem_rd_i = 1'b0;
    ifa.id_rs2_i = 5'd11; ifa.wb_rd_i = 5'd7; ifa.wb_reg_wr_i = 1'b1;
    #1;
    chk("lu3_fwd_b", ifa.fwd_b_sel_o, 2'b01);
    chk("lu3_stall_cnt", ifa.stall_cnt_o, 1);

    // Redirect while EX/MEM is a bubble: ignored.
    ifa.redirect_i = 1'b1;
    #1;
    chk("rd0_ifid_fl", ifa.if_id_flush_o, 0);
    chk("rd0_idex_fl", ifa.id_ex_flush_o, 0);
    chk("rd0_exmem_fl", ifa.ex_mem_flush_o, 0);
    chk("rd0_pc_wr", ifa.pc_wr_en_o, 1);
    tick();
    a_idle();
    ifa.redirect_i = 1'b1;
    #1;
    chk("rd1_ifid_fl", ifa.if_id_flush_o, 1);
    chk("rd1_idex_fl", ifa.id_ex_flush_o, 1);
    chk("rd1_exmem_fl", ifa.ex_mem_flush_o, 1);
    chk("rd1_stall", ifa.stall_o, 0);
    chk("rd1_flush_cnt", ifa.flush_cnt_o, 0);
    chk("rd1_retire", ifa.retire_cnt_o, 11);
    tick();
    ifa.redirect_i = 1'b0;
    #1;
    chk("rd2_flush_cnt", ifa.flush_cnt_o, 1);
    chk("rd2_retire", ifa.retire_cnt_o, 11);
    chk("rd2_ifid_fl", ifa.if_id_flush_o, 0);
    repeat (4) tick();
    chk("rd6_retire", ifa.retire_cnt_o, 12);
    chk("rd6_cyc", ifa.cyc_cnt_o, 20);
    chk("rd6_stall_cnt", ifa.stall_cnt_o, 1);
    chk("rd6_flush_cnt", ifa.flush_cnt_o, 1);

    // Load-use and redirect together: redirect wins.
    ifa.ex_rd_i = 5'd7; ifa.ex_mem_rd_i = 1'b1; ifa.id_rs2_i = 5'd7;
    ifa.redirect_i = 1'b1;
    #1;
    chk("both_stall", ifa.stall_o, 0);
    chk("both_pc_wr", ifa.pc_wr_en_o, 1);
    chk("both_exmem_fl", ifa.ex_mem_flush_o, 1);
    tick();
    a_idle();
    #1;
    chk("both_stall_cnt", ifa.stall_cnt_o, 1);
    chk("both_flush_cnt", ifa.flush_cnt_o, 2);

    // No forwarding: producer x5 one ahead of its consumer.
    ifb.ex_rd_i = 5'd5; ifb.ex_reg_wr_i = 1'b1;
    ifb.id_rs1_i = 5'd5; ifb.id_use_rs1_i = 1'b1;
    ifb.ex_rs1_i = 5'd3; ifb.mem_rd_i = 5'd3; ifb.mem_reg_wr_i = 1'b1;
    #1;
    chk("nf_stall1", ifb.stall_o, 1);
    chk("nf_pc_wr1", ifb.pc_wr_en_o, 0);
    chk("nf_fwd_off", ifb.fwd_a_sel_o, 2'b00);
    chk("nf_stall_cnt0", ifb.stall_cnt_o, 0);
    tick();
    ifb.ex_reg_wr_i = 1'b0; ifb.mem_rd_i = 5'd5; ifb.mem_reg_wr_i = 1'b1;
    #1;
    chk("nf_stall2", ifb.stall_o, 1);
    chk("nf_stall_cnt1", ifb.stall_cnt_o, 1);
    tick();
    ifb.mem_reg_wr_i = 1'b0; ifb.wb_rd_i = 5'd5; ifb.wb_reg_wr_i = 1'b1;
    #1;
    chk("nf_stall3", ifb.stall_o, 0);
    chk("nf_pc_wr3", ifb.pc_wr_en_o, 1);
    chk("nf_byp_a", ifb.id_byp_a_o, 1);
    chk("nf_byp_b", ifb.id_byp_b_o, 0);
    chk("nf_stall_cnt2", ifb.stall_cnt_o, 2);
    tick();

    // Counter clear during a stall.
    b_idle();
    ifb.ex_rd_i = 5'd6; ifb.ex_reg_wr_i = 1'b1;
    ifb.id_rs2_i = 5'd6; ifb.id_use_rs2_i = 1'b1;
    ifb.cnt_clr_i = 1'b1;
    #1;
    chk("clr_stall", ifb.stall_o, 1);
    tick();
    b_idle();
    #1;
    chk("clr_cyc", ifb.cyc_cnt_o, 0);
    chk("clr_stall_cnt", ifb.stall_cnt_o, 0);
    chk("clr_flush_cnt", ifb.flush_cnt_o, 0);
    chk("clr_retire", ifb.retire_cnt_o, 0);
    tick();
    chk("clr1_cyc", ifb.cyc_cnt_o, 1);
    chk("clr1_stall_cnt", ifb.stall_cnt_o, 0);
    chk("clr1_retire", ifb.retire_cnt_o, 0);

    // Reset in the middle of a stall.
    ifb.ex_rd_i = 5'd6; ifb.ex_reg_wr_i = 1'b1;
    ifb.id_rs2_i = 5'd6; ifb.id_use_rs2_i = 1'b1;
    #1;
    chk("rs_stall", ifb.stall_o, 1);
    rst = 1'b1;
    #1;
    chk("rs_rst_stall", ifb.stall_o, 0);
    chk("rs_rst_pc_wr", ifb.pc_wr_en_o, 0);
    chk("rs_rst_exmem_fl", ifb.ex_mem_flush_o, 1);
    tick();
    rst = 1'b0;
    #1;
    chk("rs_rel_stall", ifb.stall_o, 0);
    chk("rs_rel_pc_wr", ifb.pc_wr_en_o, 1);
    chk("rs_rel_cyc", ifb.cyc_cnt_o, 0);
    tick();
    chk("rs_rel2_stall", ifb.stall_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
